uart_rx_frame: RTL and testbench

Serial receive framer for the UART controller. It oversamples the synchronized `srx` line on the 16x baud enable, assembles 5-8 bit characters with optional parity, and detects framing errors and line breaks. Each character is pushed as one 11-bit record into the receive FIFO. It also runs the character-timeout counter used by the interrupt logic.

---
 rtl/uart_rx_frame.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive framer with 16x oversampling and character timeout
//
// Ports:
//   clk          core clock
//   nreset       asynchronous active-low reset
//   enable       16x baud tick, one clk wide
//   srx          raw serial input (idle high), asynchronous to clk
//   lcr[7:0]     line control: [1:0] word length 5..8, [2] two stop bits,
//                [3] parity enable, [4] even parity, [5] stick parity
//   rf_pop       receive FIFO pop strobe (timeout reload only)
//   rf_count_nz  receive FIFO is non-empty
//   rf_push      one-cycle push strobe to the receive FIFO
//   rf_data[10:0] {data[7:0], break, parity_err, framing_err}
//   rx_idle      framer is in IDLE
//   timeout      character timeout pending
module uart_rx_frame #(
    parameter int RX_SYNC_STAGES = 2,
    parameter int TOUT_W         = 10
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        enable,
    input  logic        srx,
    input  logic [7:0]  lcr,
    input  logic        rf_pop,
    input  logic        rf_count_nz,
    output logic        rf_push,
    output logic [10:0] rf_data,
    output logic        rx_idle,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t state, state_nx;

    logic [RX_SYNC_STAGES-1:0] sync_q;
    logic                      srx_s;

    logic [3:0]        tick, tick_nx;
    logic [2:0]        bit_idx, bit_nx;
    logic [7:0]        data, data_nx;
    logic [5:0]        fr_lcr, fr_nx;
    logic              par_bit, pbit_nx;
    logic              par_err, perr_nx;
    logic              push_nx;
    logic [10:0]       rdata_nx;
    logic              par_exp;
    logic              fe, brk;

    logic [3:0]        frame_bits;
    logic [TOUT_W-1:0] tout_reload;
    logic [TOUT_W-1:0] tout_cnt;

    logic              unused_lcr;
    assign unused_lcr = ^lcr[7:6];

    // Synchronizer flops reset to the idle (high) line level.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[RX_SYNC_STAGES-2:0], srx};
        end
    end

    assign srx_s = sync_q[RX_SYNC_STAGES-1];

    // Stick parity forces the bit; otherwise even parity makes the total XOR 0.
    assign par_exp = fr_lcr[5] ? ~fr_lcr[4] : ((^data) ^ ~fr_lcr[4]);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= IDLE;
            tick    <= 4'd0;
            bit_idx <= 3'd0;
            data    <= 8'd0;
            fr_lcr  <= 6'd0;
            par_bit <= 1'b0;
            par_err <= 1'b0;
            rf_push <= 1'b0;
            rf_data <= 11'd0;
        end else begin
            state   <= state_nx;
            tick    <= tick_nx;
            bit_idx <= bit_nx;
            data    <= data_nx;
            fr_lcr  <= fr_nx;
            par_bit <= pbit_nx;
            par_err <= perr_nx;
            rf_push <= push_nx;
            rf_data <= rdata_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tick_nx  = tick;
        bit_nx   = bit_idx;
        data_nx  = data;
        fr_nx    = fr_lcr;
        pbit_nx  = par_bit;
        perr_nx  = par_err;
        push_nx  = 1'b0;
        rdata_nx = rf_data;
        fe       = 1'b0;
        brk      = 1'b0;

        if (enable) begin
            case (state)
                IDLE: begin
                    if (!srx_s) begin
                        state_nx = START;
                        tick_nx  = 4'd7;
                    end
                end
                START: begin
                    if (tick == 4'd0) begin
                        if (!srx_s) begin
                            state_nx = DATA;
                            tick_nx  = 4'd15;
                            fr_nx    = lcr[5:0];
                            bit_nx   = 3'd0;
                            data_nx  = 8'd0;
                            pbit_nx  = 1'b0;
                            perr_nx  = 1'b0;
                        end else begin
                            state_nx = IDLE;
                        end
                    end else begin
                        tick_nx = tick - 4'd1;
                    end
                end
                DATA: begin
                    if (tick == 4'd0) begin
                        tick_nx          = 4'd15;
                        data_nx[bit_idx] = srx_s;
                        // Last bit index is word length - 1 = 4 + lcr[1:0].
                        if (bit_idx == {1'b1, fr_lcr[1:0]}) begin
                            state_nx = fr_lcr[3] ? PARITY : STOP;
                        end else begin
                            bit_nx = bit_idx + 3'd1;
                        end
                    end else begin
                        tick_nx = tick - 4'd1;
                    end
                end
                PARITY: begin
                    if (tick == 4'd0) begin
                        tick_nx  = 4'd15;
                        pbit_nx  = srx_s;
                        perr_nx  = (srx_s != par_exp);
                        state_nx = STOP;
                    end else begin
                        tick_nx = tick - 4'd1;
                    end
                end
                STOP: begin
                    if (tick == 4'd0) begin
                        fe       = ~srx_s;
                        brk      = fe & (data == 8'd0) & (~fr_lcr[3] | ~par_bit);
                        push_nx  = 1'b1;
                        rdata_nx = {data, brk, par_err, fe};
                        state_nx = brk ? WAIT_HIGH : IDLE;
                    end else begin
                        tick_nx = tick - 4'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (srx_s) begin
                        state_nx = IDLE;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign rx_idle = (state == IDLE);

    // Frame length in bits (start + data + parity + stop + extra stop), from live lcr.
    assign frame_bits  = 4'd7 + {2'b00, lcr[1:0]} + {3'b000, lcr[3]} + {3'b000, lcr[2]};
    assign tout_reload = TOUT_W'({frame_bits, 6'b000000});

    // Reload is not gated by enable so the push strobe, which falls between ticks, is seen.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            tout_cnt <= '1;
        end else if (rf_push || rf_pop || !rf_count_nz) begin
            tout_cnt <= tout_reload;
        end else if (enable && (tout_cnt != '0)) begin
            tout_cnt <= tout_cnt - TOUT_W'(1);
        end
    end

    assign timeout = (tout_cnt == '0) & rf_count_nz;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame
module tb_uart_rx_frame;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        enable = 1'b0;
    logic        srx = 1'b1;
    logic [7:0]  lcr = 8'h03;
    logic        rf_pop = 1'b0;
    logic        rf_count_nz = 1'b0;
    logic        rf_push;
    logic [10:0] rf_data;
    logic        rx_idle;
    logic        timeout;

    int errors = 0;
    int checks = 0;
    int tick_cnt = 0;

    logic [10:0] pq_data[$];
    int          pq_tick[$];

    uart_rx_frame #(.RX_SYNC_STAGES(2), .TOUT_W(10)) dut (
        .clk         (clk),
        .nreset      (nreset),
        .enable      (enable),
        .srx         (srx),
        .lcr         (lcr),
        .rf_pop      (rf_pop),
        .rf_count_nz (rf_count_nz),
        .rf_push     (rf_push),
        .rf_data     (rf_data),
        .rx_idle     (rx_idle),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rf_push) begin
            pq_data.push_back(rf_data);
            pq_tick.push_back(tick_cnt);
        end
    end

    // One 16x tick: srx settles through the synchronizer before the enable edge.
    task automatic tick(input logic v);
        srx = v;
        repeat (3) @(posedge clk);
        #1 enable = 1'b1;
        @(posedge clk);
        #1 enable = 1'b0;
        tick_cnt++;
    endtask

    task automatic ticks(input logic v, input int n);
        repeat (n) tick(v);
    endtask

    function automatic int wlen(input logic [7:0] l);
        return int'(l[1:0]) + 5;
    endfunction

    // Parity bit as transmitted: correct per line settings, inverted when bad is set.
    function automatic logic sent_par(input logic [7:0] d, input logic [7:0] l, input logic bad);
        int   ones;
        logic pb;
        ones = 0;
        for (int i = 0; i < wlen(l); i++) ones += int'(d[i]);
        if (l[5]) pb = ~l[4];
        else if (l[4]) pb = (ones % 2 == 1);
        else pb = (ones % 2 == 0);
        return pb ^ bad;
    endfunction

    function automatic logic [10:0] exp_rec(input logic [7:0] d, input logic [7:0] l,
                                            input logic bad, input logic stop_v);
        logic [7:0] dm;
        logic       pb, fe, brk;
        dm = 8'h00;
        for (int i = 0; i < wlen(l); i++) dm[i] = d[i];
        pb  = sent_par(d, l, bad);
        fe  = ~stop_v;
        brk = fe && (dm == 8'h00) && (!l[3] || !pb);
        return {dm, brk, l[3] & bad, fe};
    endfunction

    function automatic int exp_lat(input logic [7:0] l);
        return 8 + 16 * (1 + wlen(l) + int'(l[3]));
    endfunction

    // lcr is scrambled after the start bit to show the frame uses its latched copy,
    // and restored before the stop bit so the timeout reload sees the real settings.
    task automatic send_frame(input logic [7:0] d, input logic [7:0] l, input logic bad,
                              input logic stop_v, input int stop_ticks);
        lcr = l;
        ticks(1'b0, 16);
        lcr = 8'($urandom);
        for (int i = 0; i < wlen(l); i++) ticks(d[i], 16);
        if (l[3]) ticks(sent_par(d, l, bad), 16);
        lcr = l;
        ticks(stop_v, stop_ticks);
    endtask

    task automatic test_reset;
        #3;
        checks++; if (rf_push !== 1'b0) begin errors++; $display("FAIL reset_push got=%b exp=0", rf_push); end
        checks++; if (rf_data !== 11'd0) begin errors++; $display("FAIL reset_data got=%h exp=000", rf_data); end
        checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL reset_idle got=%b exp=1", rx_idle); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
        repeat (2) @(posedge clk);
        #1 nreset = 1'b1;
        ticks(1'b1, 4);
    endtask

    task automatic test_8n1;
        int t0;
        logic [10:0] got;
        int gt;
        pq_data.delete(); pq_tick.delete();
        t0 = tick_cnt + 1;
        send_frame(8'hA5, 8'h03, 1'b0, 1'b1, 16);
        ticks(1'b1, 4);
        checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL 8n1_count got=%0d exp=1", pq_data.size()); end
        if (pq_data.size() > 0) begin
            got = pq_data.pop_front(); gt = pq_tick.pop_front();
            checks++; if (got !== {8'hA5, 3'b000}) begin errors++; $display("FAIL 8n1_data got=%h exp=%h", got, {8'hA5, 3'b000}); end
            checks++; if (gt - t0 != 152) begin errors++; $display("FAIL 8n1_latency got=%0d exp=152", gt - t0); end
        end
        checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL 8n1_idle got=%b exp=1", rx_idle); end
    endtask

    task automatic test_parity;
        logic [10:0] got;
        for (int b = 0; b < 2; b++) begin
            pq_data.delete(); pq_tick.delete();
            send_frame(8'h41, 8'h1A, b[0], 1'b1, 16);
            ticks(1'b1, 4);
            checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL parity_count bad=%0d got=%0d exp=1", b, pq_data.size()); end
            if (pq_data.size() > 0) begin
                got = pq_data.pop_front();
                checks++;
                if (got !== {8'h41, 1'b0, b[0], 1'b0}) begin
                    errors++; $display("FAIL parity_data bad=%0d got=%h exp=%h", b, got, {8'h41, 1'b0, b[0], 1'b0});
                end
            end
        end
    endtask

    task automatic test_break;
        int t0;
        logic [10:0] got;
        int gt;
        pq_data.delete(); pq_tick.delete();
        lcr = 8'h03;
        t0 = tick_cnt + 1;
        ticks(1'b0, 480);
        checks++; if (rx_idle !== 1'b0) begin errors++; $display("FAIL break_busy got=%b exp=0", rx_idle); end
        checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL break_count got=%0d exp=1", pq_data.size()); end
        if (pq_data.size() > 0) begin
            got = pq_data.pop_front(); gt = pq_tick.pop_front();
            checks++; if (got !== {8'h00, 3'b101}) begin errors++; $display("FAIL break_data got=%h exp=%h", got, {8'h00, 3'b101}); end
            checks++; if (gt - t0 != 152) begin errors++; $display("FAIL break_latency got=%0d exp=152", gt - t0); end
        end
        tick(1'b1);
        checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL break_release got=%b exp=1", rx_idle); end
        ticks(1'b1, 4);
        checks++; if (pq_data.size() != 0) begin errors++; $display("FAIL break_extra got=%0d exp=0", pq_data.size()); end
    endtask

    task automatic test_glitch;
        logic [10:0] got;
        pq_data.delete(); pq_tick.delete();
        ticks(1'b0, 4);
        ticks(1'b1, 12);
        checks++; if (pq_data.size() != 0) begin errors++; $display("FAIL glitch_push got=%0d exp=0", pq_data.size()); end
        checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL glitch_idle got=%b exp=1", rx_idle); end
        send_frame(8'h1F, 8'h00, 1'b0, 1'b1, 16);
        ticks(1'b1, 4);
        checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", pq_data.size()); end
        if (pq_data.size() > 0) begin
            got = pq_data.pop_front();
            checks++; if (got !== {8'h1F, 3'b000}) begin errors++; $display("FAIL glitch_next_data got=%h exp=%h", got, {8'h1F, 3'b000}); end
        end
    endtask

    // Second start bit begins on the tick right after the stop sample.
    task automatic test_back_to_back;
        int t0, t1;
        logic [10:0] got;
        int gt;
        pq_data.delete(); pq_tick.delete();
        t0 = tick_cnt + 1;
        send_frame(8'h3C, 8'h03, 1'b0, 1'b1, 9);
        t1 = tick_cnt + 1;
        send_frame(8'hC3, 8'h03, 1'b0, 1'b1, 16);
        ticks(1'b1, 4);
        checks++; if (pq_data.size() != 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", pq_data.size()); end
        if (pq_data.size() == 2) begin
            got = pq_data.pop_front(); gt = pq_tick.pop_front();
            checks++; if (got !== {8'h3C, 3'b000} || gt - t0 != 152) begin
                errors++; $display("FAIL b2b_first got=%h@%0d exp=%h@152", got, gt - t0, {8'h3C, 3'b000});
            end
            got = pq_data.pop_front(); gt = pq_tick.pop_front();
            checks++; if (got !== {8'hC3, 3'b000} || gt - t1 != 152) begin
                errors++; $display("FAIL b2b_second got=%h@%0d exp=%h@152", got, gt - t1, {8'hC3, 3'b000});
            end
        end
    endtask

    task automatic test_random;
        logic [7:0]  d, l;
        logic        bad, stop_v;
        int          t0, st, gt;
        logic [10:0] got, exp;
        for (int n = 0; n < 20; n++) begin
            pq_data.delete(); pq_tick.delete();
            d      = 8'($urandom);
            l      = 8'($urandom);
            bad    = 1'($urandom);
            stop_v = ($urandom_range(0, 3) != 0);
            if (n % 5 == 0) d = 8'h00;
            st     = stop_v ? (l[2] ? 32 : 16) : 9;
            exp    = exp_rec(d, l, bad, stop_v);
            t0     = tick_cnt + 1;
            send_frame(d, l, bad, stop_v, st);
            ticks(1'b1, 3);
            checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL rand%0d_count got=%0d exp=1", n, pq_data.size()); end
            if (pq_data.size() > 0) begin
                got = pq_data.pop_front(); gt = pq_tick.pop_front();
                checks++; if (got !== exp) begin errors++; $display("FAIL rand%0d_data lcr=%h got=%h exp=%h", n, l, got, exp); end
                checks++; if (gt - t0 != exp_lat(l)) begin errors++; $display("FAIL rand%0d_latency got=%0d exp=%0d", n, gt - t0, exp_lat(l)); end
            end
            checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL rand%0d_idle got=%b exp=1", n, rx_idle); end
        end
    endtask

    task automatic test_timeout;
        int n;
        pq_data.delete(); pq_tick.delete();
        rf_count_nz = 1'b0;
        send_frame(8'h77, 8'h03, 1'b0, 1'b1, 16);
        ticks(1'b1, 2);
        checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL tout_push got=%0d exp=1", pq_data.size()); end
        rf_count_nz = 1'b1;
        n = 0;
        while (n < 2000) begin
            tick(1'b1); n++;
            if (timeout === 1'b1) break;
        end
        checks++; if (n != 640) begin errors++; $display("FAIL tout_first got=%0d exp=640 ticks", n); end
        rf_pop = 1'b1;
        @(posedge clk);
        #1 rf_pop = 1'b0;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tout_pop_clear got=%b exp=0", timeout); end
        n = 0;
        while (n < 2000) begin
            tick(1'b1); n++;
            if (n == 320) repeat (200) @(posedge clk);
            if (timeout === 1'b1) break;
        end
        checks++; if (n != 640) begin errors++; $display("FAIL tout_reload got=%0d exp=640 ticks", n); end
        rf_count_nz = 1'b0;
        @(posedge clk); #1;
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL tout_empty got=%b exp=0", timeout); end
    endtask

    task automatic test_reset_mid;
        logic [10:0] got;
        pq_data.delete(); pq_tick.delete();
        lcr = 8'h03;
        ticks(1'b0, 16);
        ticks(1'b1, 20);
        #2 nreset = 1'b0;
        #1;
        checks++; if (rx_idle !== 1'b1) begin errors++; $display("FAIL rstmid_idle got=%b exp=1", rx_idle); end
        checks++; if (rf_data !== 11'd0) begin errors++; $display("FAIL rstmid_data got=%h exp=000", rf_data); end
        @(posedge clk);
        #1 nreset = 1'b1;
        ticks(1'b1, 200);
        checks++; if (pq_data.size() != 0) begin errors++; $display("FAIL rstmid_push got=%0d exp=0", pq_data.size()); end
        send_frame(8'h5A, 8'h03, 1'b0, 1'b1, 16);
        ticks(1'b1, 4);
        checks++; if (pq_data.size() != 1) begin errors++; $display("FAIL rstmid_next_count got=%0d exp=1", pq_data.size()); end
        if (pq_data.size() > 0) begin
            got = pq_data.pop_front();
            checks++; if (got !== {8'h5A, 3'b000}) begin errors++; $display("FAIL rstmid_next_data got=%h exp=%h", got, {8'h5A, 3'b000}); end
        end
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_break;
        test_glitch;
        test_back_to_back;
        test_random;
        test_timeout;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
